// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// One outstanding read or write at a time; a silent memory is aborted with req_error.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module mem_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*MDATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           req_error,
    output logic [MDATA_WIDTH-1:0]         req_rdata,
    output logic                           busy,
    output logic [MADDR_WIDTH-1:0]         mem_addr,
    output logic [MDATA_WIDTH-1:0]         mem_wdata,
    output logic                           mem_read_enable,
    output logic                           mem_write_enable,
    input  logic [MDATA_WIDTH-1:0]         mem_data,
    input  logic                           mem_read_ready
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0] rr_ptr, grant, pick;
    logic             found, wr_lat;
    logic [CNT_W-1:0] tmo_cnt, tmo_inc;
    logic             tmo_hit;

    logic [MADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [MDATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [NUM_REQ-1:0]     ack_nxt;
    logic                   err_nxt, re_nxt, we_nxt, busy_nxt;
    logic [MDATA_WIDTH-1:0] rdata_nxt, wdata_nxt;
    logic [MADDR_WIDTH-1:0] addr_nxt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*MADDR_WIDTH +: MADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*MDATA_WIDTH +: MDATA_WIDTH];
    end

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign tmo_inc = tmo_cnt + CNT_W'(1);
    assign tmo_hit = (tmo_inc == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mem_read_ready || tmo_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so they are valid in the state they belong to.
    always_comb begin
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        rdata_nxt = '0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        re_nxt    = 1'b0;
        we_nxt    = 1'b0;
        busy_nxt  = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: if (found) begin
                addr_nxt  = addr_arr[pick];
                wdata_nxt = wdata_arr[pick];
                re_nxt    = ~req_write[pick];
                we_nxt    = req_write[pick];
            end
            S_WAIT: if (mem_read_ready || tmo_hit) begin
                ack_nxt[grant] = 1'b1;
                err_nxt        = ~mem_read_ready;
                rdata_nxt      = (mem_read_ready && !wr_lat) ? mem_data : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            grant   <= '0;
            wr_lat  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (found) begin
                    grant  <= pick;
                    wr_lat <= req_write[pick];
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT:  if (!mem_read_ready) tmo_cnt <= tmo_inc;
                S_DONE:  rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ack          <= '0;
            req_error        <= 1'b0;
            req_rdata        <= '0;
            busy             <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
        end else begin
            req_ack          <= ack_nxt;
            req_error        <= err_nxt;
            req_rdata        <= rdata_nxt;
            busy             <= busy_nxt;
            mem_addr         <= addr_nxt;
            mem_wdata        <= wdata_nxt;
            mem_read_enable  <= re_nxt;
            mem_write_enable <= we_nxt;
        end
    end
endmodule
